// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// A requester keeps ownership across a multi-byte message until its last byte, a timeout or a drop of req.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LAUNCH    = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]    state;
  logic [PW-1:0] owner;
  logic [PW-1:0] rr_ptr;
  logic          locked;
  logic          last_q;
  logic [15:0]   cnt;

  logic          win_valid;
  logic [PW-1:0] win_idx;
  int            cand;
  logic          sel_valid;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] owner_next;
  logic          done_hit;
  logic          to_hit;

  // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    sel_valid  = locked ? req[owner] : win_valid;
    sel_idx    = locked ? owner : win_idx;
    owner_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    done_hit   = (state == S_WAIT_DONE) && tx_done;
    to_hit     = (state == S_WAIT_DONE) && !tx_done && (cnt == CNT_LAST);
  end

  // Completion and abort strobes are decoded in the completion cycle itself so grant still names the owner.
  assign ack         = done_hit ? grant : '0;
  assign timeout_err = to_hit;
  assign tx_start    = (state == S_LAUNCH);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      locked  <= 1'b0;
      last_q  <= 1'b0;
      cnt     <= '0;
      grant   <= '0;
      tx_data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (locked && !req[owner]) begin
            locked <= 1'b0;
            grant  <= '0;
            rr_ptr <= owner_next;
          end else if (sel_valid && !tx_busy) begin
            state   <= S_LAUNCH;
            owner   <= sel_idx;
            grant   <= NUM_REQ'(1) << sel_idx;
            tx_data <= req_data[8*int'(sel_idx) +: 8];
            last_q  <= req_last[sel_idx];
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT_DONE;
          cnt   <= '0;
        end
        S_WAIT_DONE: begin
          if (done_hit) begin
            state <= S_IDLE;
            if (last_q) begin
              locked <= 1'b0;
              grant  <= '0;
              rr_ptr <= owner_next;
            end else begin
              locked <= 1'b1;
            end
          end else if (to_hit) begin
            state  <= S_IDLE;
            locked <= 1'b0;
            grant  <= '0;
            rr_ptr <= owner_next;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single/lock traffic plus sequences
// for lock drop, busy hold-off, done-vs-timeout, reset mid-transfer, round-robin and timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int passes = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .grant(grant), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        busy_in;
    logic        done;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_start;
    logic [7:0]  e_txd;
    logic        e_to;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic [3:0] rq, input logic [3:0] lst, input logic [31:0] d,
                               input logic b, input logic dn, input logic [3:0] g, input logic [3:0] a,
                               input logic s, input logic [7:0] t, input logic to, input logic bz);
    vec_t v;
    v.req = rq; v.last = lst; v.data = d; v.busy_in = b; v.done = dn;
    v.e_grant = g; v.e_ack = a; v.e_start = s; v.e_txd = t; v.e_to = to; v.e_busy = bz;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                               input logic [31:0] d, input logic b, input logic dn);
    @(negedge clk);
    rst = r; req = rq; req_last = lst; req_data = d; tx_busy = b; tx_done = dn;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_launch(input logic [3:0] rq, input logic [3:0] lst, input logic [31:0] d,
                             input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      applyStimulus(1'b0, rq, lst, d, 1'b0, 1'b0);
      if (tx_start === 1'b1) seen = 1'b1;
    end
    checkOutput({name, " launch"}, 32'(seen), 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen_k;
    int cnt_a;
    int cnt_b;

    rst = 1'b1; req = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;

    //          req     last    data          bsy done  grant   ack     st  txd    to  busy
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mkv(4'h4, 4'h4, 32'h00A5_0000, 0, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 0, 4'h4, 4'h0, 1, 8'hA5, 0, 1));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 0, 4'h4, 4'h0, 0, 8'hA5, 0, 1));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 1, 4'h4, 4'h4, 0, 8'hA5, 0, 1));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 0, 4'h0, 4'h0, 0, 8'hA5, 0, 0));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E111, 0, 0, 4'h0, 4'h0, 0, 8'hA5, 0, 0));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E111, 0, 0, 4'h1, 4'h0, 1, 8'h11, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E111, 0, 1, 4'h1, 4'h1, 0, 8'h11, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E122, 0, 0, 4'h1, 4'h0, 0, 8'h11, 0, 0));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E122, 0, 0, 4'h1, 4'h0, 1, 8'h22, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E122, 0, 1, 4'h1, 4'h1, 0, 8'h22, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h1, 32'h0000_E133, 0, 0, 4'h1, 4'h0, 0, 8'h22, 0, 0));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E133, 0, 0, 4'h1, 4'h0, 1, 8'h33, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h0, 32'h0000_E133, 0, 1, 4'h1, 4'h1, 0, 8'h33, 0, 1));
    tbl.push_back(mkv(4'h3, 4'h2, 32'h0000_E133, 0, 0, 4'h0, 4'h0, 0, 8'h33, 0, 0));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 1, 4'h2, 4'h0, 1, 8'hE1, 0, 1));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 1, 4'h2, 4'h2, 0, 8'hE1, 0, 1));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 1, 4'h0, 4'h0, 0, 8'hE1, 0, 0));
    tbl.push_back(mkv(4'h0, 4'h0, 32'h0000_0000, 0, 0, 4'h0, 4'h0, 0, 8'hE1, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      applyStimulus(1'b0, tbl[i].req, tbl[i].last, tbl[i].data, tbl[i].busy_in, tbl[i].done);
      checkOutput($sformatf("vec%0d grant", i),       32'(grant),       32'(tbl[i].e_grant));
      checkOutput($sformatf("vec%0d ack", i),         32'(ack),         32'(tbl[i].e_ack));
      checkOutput($sformatf("vec%0d tx_start", i),    32'(tx_start),    32'(tbl[i].e_start));
      checkOutput($sformatf("vec%0d tx_data", i),     32'(tx_data),     32'(tbl[i].e_txd));
      checkOutput($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].e_to));
      checkOutput($sformatf("vec%0d busy", i),        32'(busy),        32'(tbl[i].e_busy));
    end

    // Locked owner drops req: one cycle holding grant, one released idle cycle, then normal arbitration.
    applyStimulus(1'b0, 4'h1, 4'h0, 32'h0000_0077, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h1, 4'h0, 32'h0000_0077, 1'b0, 1'b0);
    checkOutput("drop launch grant", 32'(grant), 32'h1);
    applyStimulus(1'b0, 4'h1, 4'h0, 32'h0000_0077, 1'b0, 1'b1);
    checkOutput("drop ack", 32'(ack), 32'h1);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h005A_0000, 1'b0, 1'b0);
    checkOutput("drop lock held grant", 32'(grant), 32'h1);
    checkOutput("drop lock held start", 32'(tx_start), 32'h0);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h005A_0000, 1'b0, 1'b0);
    checkOutput("drop released grant", 32'(grant), 32'h0);
    checkOutput("drop released start", 32'(tx_start), 32'h0);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h005A_0000, 1'b0, 1'b0);
    checkOutput("drop next grant", 32'(grant), 32'h4);
    checkOutput("drop next data", 32'(tx_data), 32'h5A);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("drop next ack", 32'(ack), 32'h4);

    // tx_busy holds off the launch; tx_done landing on the timeout cycle must ack only.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'h4, 4'h4, 32'h00C3_0000, 1'b1, 1'b0);
      cnt_a += int'(tx_start);
      cnt_b += int'(busy);
    end
    checkOutput("busy hold starts", 32'(cnt_a), 32'h0);
    checkOutput("busy hold busy", 32'(cnt_b), 32'h0);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h00C3_0000, 1'b0, 1'b0);
    checkOutput("busy release idle", 32'(tx_start), 32'h0);
    applyStimulus(1'b0, 4'h4, 4'h4, 32'h00C3_0000, 1'b0, 1'b0);
    checkOutput("busy launch start", 32'(tx_start), 32'h1);
    checkOutput("busy launch grant", 32'(grant), 32'h4);
    checkOutput("busy launch data", 32'(tx_data), 32'hC3);
    cnt_a = 0;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
      cnt_a += int'(timeout_err) + int'(ack != 4'h0);
    end
    checkOutput("collide early strobes", 32'(cnt_a), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("collide ack", 32'(ack), 32'h4);
    checkOutput("collide timeout_err", 32'(timeout_err), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("collide after grant", 32'(grant), 32'h0);
    checkOutput("collide after busy", 32'(busy), 32'h0);

    // Reset while waiting for tx_done; the pointer must restart at 0 so requester 1 beats requester 3.
    applyStimulus(1'b0, 4'h8, 4'h8, 32'h5D00_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h8, 4'h8, 32'h5D00_0000, 1'b0, 1'b0);
    checkOutput("rst pre grant", 32'(grant), 32'h8);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'hA, 4'hA, 32'h0000_B200, 1'b0, 1'b1);
    checkOutput("rst grant", 32'(grant), 32'h0);
    checkOutput("rst ack", 32'(ack), 32'h0);
    checkOutput("rst tx_start", 32'(tx_start), 32'h0);
    checkOutput("rst tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst timeout_err", 32'(timeout_err), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 4'hA, 4'hA, 32'h0000_B200, 1'b0, 1'b0);
    checkOutput("rst regrant start", 32'(tx_start), 32'h1);
    checkOutput("rst regrant grant", 32'(grant), 32'h2);
    checkOutput("rst regrant data", 32'(tx_data), 32'hB2);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("rst regrant ack", 32'(ack), 32'h2);

    // Round-robin with all four requesters held high.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      exp_g = 4'h1 << (k % 4);
      exp_d = 8'(8'h11 * ((k % 4) + 1));
      wait_launch(4'hF, 4'hF, 32'h4433_2211, $sformatf("rr%0d", k));
      checkOutput($sformatf("rr%0d grant", k), 32'(grant), 32'(exp_g));
      checkOutput($sformatf("rr%0d data", k), 32'(tx_data), 32'(exp_d));
      applyStimulus(1'b0, 4'hF, 4'hF, 32'h4433_2211, 1'b0, 1'b1);
      checkOutput($sformatf("rr%0d ack", k), 32'(ack), 32'(exp_g));
    end

    // Timeout: no tx_done ever; abort 16 cycles after tx_start, then requester 1 gets served.
    do_reset();
    wait_launch(4'h3, 4'h3, 32'h0000_BBAA, "to");
    checkOutput("to grant", 32'(grant), 32'h1);
    seen_k = 0;
    for (int k = 1; k <= 20 && seen_k == 0; k++) begin
      applyStimulus(1'b0, 4'h3, 4'h3, 32'h0000_BBAA, 1'b0, 1'b0);
      if (timeout_err === 1'b1) begin
        seen_k = k;
        checkOutput("to ack", 32'(ack), 32'h0);
        checkOutput("to grant held", 32'(grant), 32'h1);
      end
    end
    checkOutput("to latency", 32'(seen_k), 32'd16);
    applyStimulus(1'b0, 4'h3, 4'h3, 32'h0000_BBAA, 1'b0, 1'b0);
    checkOutput("to pulse width", 32'(timeout_err), 32'h0);
    checkOutput("to released grant", 32'(grant), 32'h0);
    wait_launch(4'h3, 4'h3, 32'h0000_BBAA, "to next");
    checkOutput("to next grant", 32'(grant), 32'h2);
    checkOutput("to next data", 32'(tx_data), 32'hBB);
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("to next ack", 32'(ack), 32'h2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
